hazard_track_unit: RTL

Parametrised successor to the pipeline forwarding logic. Tracks in-flight register writes in an internal shadow pipeline of NSTAGES post-EX stages, and produces per-source forwarding selects and a load-use / late-result stall for the instruction currently in ID/EX. It sits beside the ID/EX register; its stall output holds the IF/ID and ID/EX registers and inserts a bubble into EX.

---
 rtl/hazard_track_unit.sv | 111 +++++++++++
 1 files changed

// File: rtl/hazard_track_unit.sv
// hazard_track_unit: shadow pipeline of in-flight register writes beside ID/EX.
// Produces per-source forwarding selects and a load-use / late-result stall
// for the instruction currently in ID/EX.
module hazard_track_unit #(
    parameter int unsigned NUM_SRC = 2,
    parameter int unsigned NSTAGES = 3,
    parameter int unsigned RA_W    = 5,
    parameter int unsigned RDY_W   = 2,
    parameter int unsigned SEL_W   = $clog2(NSTAGES + 1)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       hold,
    input  logic                       fwd_en,
    input  logic                       ex_valid,
    input  logic                       ex_wen,
    input  logic [RA_W-1:0]            ex_rd,
    input  logic [RDY_W-1:0]           ex_rdy_stage,
    input  logic [NUM_SRC-1:0]         src_valid,
    input  logic [NUM_SRC*RA_W-1:0]    src_addr,
    output logic [NUM_SRC*SEL_W-1:0]   fwd_sel,
    output logic                       stall,
    output logic [15:0]                stall_cnt,
    output logic [NSTAGES-1:0]         entry_valid
);

    localparam int unsigned CNT_W = 16;

    // Tracked entries: index 0 = EX/MEM, NSTAGES-1 = oldest.
    logic [NSTAGES-1:0] r_vld;
    logic [NSTAGES-1:0] r_wen;
    logic [RA_W-1:0]    r_rd  [NSTAGES];
    logic [RDY_W-1:0]   r_rdy [NSTAGES];
    logic [CNT_W-1:0]   r_stall_cnt;

    logic [RDY_W-1:0]   w_rdy_clamp;
    logic [NUM_SRC-1:0] w_req;
    logic               w_hit;
    int unsigned        w_idx;
    int unsigned        w_hit_rdy;

    // A result-ready stage past the last tracked entry is treated as the last entry.
    assign w_rdy_clamp = (32'(ex_rdy_stage) >= NSTAGES) ? RDY_W'(NSTAGES - 1) : ex_rdy_stage;

    // Shift the shadow pipeline; a stall drops a bubble into entry 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld <= '0;
            r_wen <= '0;
            for (int i = 0; i < NSTAGES; i++) begin
                r_rd[i]  <= '0;
                r_rdy[i] <= '0;
            end
        end else if (!hold) begin
            r_vld[0] <= ex_valid & ~stall;
            r_wen[0] <= ex_wen;
            r_rd[0]  <= ex_rd;
            r_rdy[0] <= w_rdy_clamp;
            for (int i = 1; i < NSTAGES; i++) begin
                r_vld[i] <= r_vld[i-1];
                r_wen[i] <= r_wen[i-1];
                r_rd[i]  <= r_rd[i-1];
                r_rdy[i] <= r_rdy[i-1];
            end
        end
    end

    // Youngest-match search per source; forward if that producer's result exists yet.
    always_comb begin
        fwd_sel   = '0;
        w_req     = '0;
        w_hit     = 1'b0;
        w_idx     = 0;
        w_hit_rdy = 0;
        for (int k = 0; k < NUM_SRC; k++) begin
            w_hit     = 1'b0;
            w_idx     = 0;
            w_hit_rdy = 0;
            for (int i = 0; i < NSTAGES; i++) begin
                if (!w_hit && src_valid[k] && r_vld[i] && r_wen[i] &&
                    (r_rd[i] != '0) && (r_rd[i] == src_addr[k*RA_W +: RA_W])) begin
                    w_hit     = 1'b1;
                    w_idx     = 32'(i);
                    w_hit_rdy = 32'(r_rdy[i]);
                end
            end
            if (w_hit) begin
                if (fwd_en && (w_idx >= w_hit_rdy)) begin
                    fwd_sel[k*SEL_W +: SEL_W] = SEL_W'(w_idx + 1);
                end else begin
                    w_req[k] = 1'b1;
                end
            end
        end
    end

    assign stall = ex_valid & (|w_req);

    // Saturating count of stall cycles that actually advance the pipeline.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (!hold && stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign stall_cnt   = r_stall_cnt;
    assign entry_valid = r_vld;

endmodule
